// File: rtl/enc_pkg.sv
// enc_pkg: shared widths and types for the 8-to-3 priority encoder
package enc_pkg;
  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;
  typedef logic [ENC_IN_W-1:0]  enc_in_t;
  typedef logic [ENC_OUT_W-1:0] enc_code_t;
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: combinational highest-bit-wins encoder; ENC_ONEHOT_CHECK_EN enables the multi-hot flag
module prio_enc8
  import enc_pkg::*;
(
  input  enc_in_t   din,
  output enc_code_t code,
  output logic      any,
  output logic      multi
);
  // scan upward so the highest set bit is the last one to claim the code
  always_comb begin
    code = '0;
    for (int i = 0; i < ENC_IN_W; i++) code = din[i] ? enc_code_t'(i) : code;
  end
  assign any = |din;
`ifdef ENC_ONEHOT_CHECK_EN
  assign multi = |(din & (din - enc_in_t'(1)));
`else
  assign multi = 1'b0;
`endif
endmodule

// File: rtl/eight_to_three_encoder.sv
// eight_to_three_encoder: registered priority encoder, optional input stage; ENC_ONEHOT_CHECK_EN enables err
module eight_to_three_encoder
  import enc_pkg::*;
#(
  parameter int IN_REG = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  enc_in_t   din,
  output enc_code_t dout,
  output logic      valid,
  output logic      err
);
  enc_in_t   src;
  logic      adv;
  enc_code_t code, dout_d, dout_q;
  logic      any, multi, valid_d, valid_q, err_d, err_q;
  if (IN_REG != 0) begin : g_in
    enc_in_t stage_d, stage_q;
    // input stage captures din only when enabled; the output stage follows it every cycle
    always_comb stage_d = en ? din : stage_q;
    // input stage register
    always_ff @(posedge clk or posedge rst)
      if (rst) stage_q <= '0;
      else stage_q <= stage_d;
    assign src = stage_q;
    assign adv = 1'b1;
  end else begin : g_direct
    assign src = din;
    assign adv = en;
  end
  prio_enc8 u_enc (.din(src), .code(code), .any(any), .multi(multi));
  // all three outputs load from the same sample or all hold
  always_comb begin
    dout_d  = adv ? code  : dout_q;
    valid_d = adv ? any   : valid_q;
    err_d   = adv ? multi : err_q;
  end
  // output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  assign dout  = dout_q;
  assign valid = valid_q;
  assign err   = err_q;
endmodule

// File: tb/tb_eight_to_three_encoder.sv
// tb_eight_to_three_encoder: vector table, corner sequences and random check of both latency variants
module tb_eight_to_three_encoder;
  import enc_pkg::*;
`ifdef ENC_ONEHOT_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif
  logic clk = 0, rst = 1, en = 0;
  enc_in_t din = '0;
  enc_code_t dout0, dout1;
  logic valid0, valid1, err0, err1;
  int total = 0, bad = 0;
  logic [4:0] m0, m1;
  enc_in_t s1;

  eight_to_three_encoder #(.IN_REG(0)) u0 (.clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout0), .valid(valid0), .err(err0));
  eight_to_three_encoder #(.IN_REG(1)) u1 (.clk(clk), .rst(rst), .en(en), .din(din),
    .dout(dout1), .valid(valid1), .err(err1));

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_enc(enc_in_t d);
    int hi = -1, n = 0;
    for (int i = 0; i < 8; i++) if (d[i]) begin hi = i; n++; end
    return {(hi < 0) ? 3'd0 : 3'(hi), n > 0, ERR_ON && n > 1};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got dout/valid/err=%b/%b/%b want %b/%b/%b", name,
        act[4:2], act[1], act[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic step;
    @(posedge clk);
    if (rst) begin m0 = '0; m1 = '0; s1 = '0; end
    else begin
      if (en) m0 = ref_enc(din);
      m1 = ref_enc(s1);
      if (en) s1 = din;
    end
    #1;
    chk("model_lat1", {dout0, valid0, err0}, m0);
    chk("model_lat2", {dout1, valid1, err1}, m1);
  endtask

  typedef struct { enc_in_t d; enc_code_t c; logic v; logic e; } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{8'b1000_0000, 3'd7, 1, 0};
    tbl[1]  = '{8'b0100_0000, 3'd6, 1, 0};
    tbl[2]  = '{8'b0010_0000, 3'd5, 1, 0};
    tbl[3]  = '{8'b0001_0000, 3'd4, 1, 0};
    tbl[4]  = '{8'b0000_1000, 3'd3, 1, 0};
    tbl[5]  = '{8'b0000_0100, 3'd2, 1, 0};
    tbl[6]  = '{8'b0000_0010, 3'd1, 1, 0};
    tbl[7]  = '{8'b0000_0001, 3'd0, 1, 0};
    tbl[8]  = '{8'b0000_0000, 3'd0, 0, 0};
    tbl[9]  = '{8'b0101_0000, 3'd6, 1, 1};
    tbl[10] = '{8'b0010_0110, 3'd5, 1, 1};
    tbl[11] = '{8'b1111_1111, 3'd7, 1, 1};
    tbl[12] = '{8'b0000_0011, 3'd1, 1, 1};
    tbl[13] = '{8'b1000_0001, 3'd7, 1, 1};
    m0 = '0; m1 = '0; s1 = '0;
    #2;
    chk("reset_u0", {dout0, valid0, err0}, 5'b0);
    chk("reset_u1", {dout1, valid1, err1}, 5'b0);
    step;
    rst = 0;
    en = 1;
    foreach (tbl[k]) begin
      din = tbl[k].d;
      step;
      chk($sformatf("vec%0d", k), {dout0, valid0, err0}, {tbl[k].c, tbl[k].v, tbl[k].e & ERR_ON});
    end
    din = 8'b0000_1000;
    step;
    en = 0;
    din = 8'b1000_0000;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("hold_u0", {dout0, valid0, err0}, 5'b011_1_0);
      chk("hold_u1", {dout1, valid1, err1}, 5'b011_1_0);
    end
    en = 1;
    step;
    chk("pre_rst", {dout0, valid0, err0}, 5'b111_1_0);
    #2 rst = 1;
    #1;
    chk("async_rst_u0", {dout0, valid0, err0}, 5'b0);
    chk("async_rst_u1", {dout1, valid1, err1}, 5'b0);
    step;
    #2 rst = 0;
    en = 0;
    for (int k = 0; k < 2; k++) begin
      step;
      chk("post_rst_idle", {dout0, valid0, err0}, 5'b0);
    end
    en = 1;
    din = 8'b0100_0000;
    step;
    chk("lat1_first", {dout0, valid0, err0}, 5'b110_1_0);
    chk("lat2_not_yet", {dout1, valid1, err1}, 5'b0);
    din = 8'b0000_0000;
    step;
    chk("lat2_arrive", {dout1, valid1, err1}, 5'b110_1_0);
    for (int k = 0; k < 300; k++) begin
      en = ($urandom_range(3) != 0);
      case ($urandom_range(3))
        0: din = enc_in_t'(1) << $urandom_range(7);
        1: din = '0;
        default: din = enc_in_t'($urandom);
      endcase
      if (k % 97 == 50) begin
        #2 rst = 1;
        #1;
        chk("rand_rst", {dout0, valid0, err0, dout1, valid1, err1} == 10'b0 ? 5'b0 : 5'b11111, 5'b0);
        step;
        #2 rst = 0;
      end else step;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
